// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Sequences stalls, hazard bubbles, memory freezes and branch flushes for the
//   5-stage core. A multi-cycle hazard stall is issued once; a down-counter then
//   drains the remaining bubbles without re-sampling the hazard code.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_RUN   | normal issue; stall_req evaluated every cycle
//   ST_STALL | draining bubbles of an accepted hazard; r_cnt = bubbles left
//
// Ports
//   i_clk             core clock
//   i_rst_n           synchronous active-low reset
//   i_stall_req[1:0]  hazard code: 0 none, 1/3 producer in P2, 2 producer in P3
//   i_flush_req       taken branch/jump resolved in EX
//   i_mem_wait        data memory not ready; freezes the whole pipeline
//   i_perf_clr        synchronous clear of o_hazard_cycles
//   o_pc_en           PC load enable
//   o_if_id_en        IF/ID enable
//   o_if_id_flush     IF/ID loads a NOP
//   o_id_ex_en        ID/EX enable
//   o_id_ex_bubble    ID/EX loads a NOP (meaningful with o_id_ex_en=1)
//   o_ex_mem_en       EX/MEM and MEM/WB enables
//   o_busy            high while in ST_STALL
//   o_hazard_cycles   saturating count of hazard-bubble cycles
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int P2_BUBBLES = 2,
  parameter int P3_BUBBLES = 1,
  parameter int PERF_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [1:0]        i_stall_req,
  input  logic              i_flush_req,
  input  logic              i_mem_wait,
  input  logic              i_perf_clr,
  output logic              o_pc_en,
  output logic              o_if_id_en,
  output logic              o_if_id_flush,
  output logic              o_id_ex_en,
  output logic              o_id_ex_bubble,
  output logic              o_ex_mem_en,
  output logic              o_busy,
  output logic [PERF_W-1:0] o_hazard_cycles
);

  // The bubble counter is 3 bits wide, so only 1..7 bubbles are representable.
  if (P2_BUBBLES < 1 || P2_BUBBLES > 7) begin : g_bad_p2
    $error("pipeline_stall_ctrl: P2_BUBBLES must be in 1..7");
  end
  if (P3_BUBBLES < 1 || P3_BUBBLES > 7) begin : g_bad_p3
    $error("pipeline_stall_ctrl: P3_BUBBLES must be in 1..7");
  end
  if (PERF_W < 1) begin : g_bad_pw
    $error("pipeline_stall_ctrl: PERF_W must be at least 1");
  end

  localparam logic [2:0] N_P2 = 3'(P2_BUBBLES);
  localparam logic [2:0] N_P3 = 3'(P3_BUBBLES);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t              r_st;
  state_t              w_st_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [PERF_W-1:0]   r_hazard_cycles;

  logic [2:0]          w_n;
  logic                w_hazard;
  logic                w_bubble_cycle;

  // Code 3 is folded onto the P2 case.
  assign w_n      = (i_stall_req == 2'd2) ? N_P3 : N_P2;
  assign w_hazard = (i_stall_req != 2'd0);

  // A hazard bubble only happens when neither freeze nor flush overrides it.
  assign w_bubble_cycle = !i_mem_wait && !i_flush_req &&
                          ((r_st == ST_STALL) || w_hazard);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_st  <= ST_RUN;
      r_cnt <= 3'd0;
    end else begin
      r_st  <= w_st_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    if (i_mem_wait) begin
      w_st_nxt  = r_st;
      w_cnt_nxt = r_cnt;
    end else if (i_flush_req) begin
      w_st_nxt  = ST_RUN;
      w_cnt_nxt = 3'd0;
    end else begin
      case (r_st)
        ST_RUN: begin
          // The current cycle is already the first bubble, so N-1 remain.
          if (w_hazard && (w_n > 3'd1)) begin
            w_st_nxt  = ST_STALL;
            w_cnt_nxt = w_n - 3'd1;
          end
        end
        ST_STALL: begin
          w_cnt_nxt = r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            w_st_nxt = ST_RUN;
          end
        end
        default: begin
          w_st_nxt  = ST_RUN;
          w_cnt_nxt = 3'd0;
        end
      endcase
    end
  end

  // Output decode (combinational so a new hazard stalls in the detecting cycle)
  always_comb begin
    o_pc_en        = 1'b1;
    o_if_id_en     = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_en     = 1'b1;
    o_id_ex_bubble = 1'b0;
    o_ex_mem_en    = 1'b1;
    o_busy         = (r_st == ST_STALL);
    if (!i_rst_n) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_en     = 1'b0;
      o_id_ex_bubble = 1'b1;
      o_ex_mem_en    = 1'b0;
      o_busy         = 1'b0;
    end else if (i_mem_wait) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_en     = 1'b0;
      o_ex_mem_en    = 1'b0;
    end else if (i_flush_req) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if ((r_st == ST_STALL) || w_hazard) begin
      o_pc_en        = 1'b0;
      o_if_id_en     = 1'b0;
      o_id_ex_bubble = 1'b1;
    end
  end

  // Hazard performance counter; clear beats increment, saturates at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_hazard_cycles <= '0;
    end else if (i_perf_clr) begin
      r_hazard_cycles <= '0;
    end else if (w_bubble_cycle && (r_hazard_cycles != {PERF_W{1'b1}})) begin
      r_hazard_cycles <= r_hazard_cycles + 1'b1;
    end
  end

  assign o_hazard_cycles = r_hazard_cycles;

endmodule
